taint_sink_monitor: RTL and testbench

- Consumer end of the tagged-signal flow. Upstream instrumented logic drives each value together with a 32-bit taint tag; this block sits at a protected sink.
- It accepts a valid/ready stream of value+tag pairs and checks each tag against a programmable policy mask.
- It latches the first violating transfer, raises a registered alarm, and counts violations until software acknowledges.

---
 rtl/taint_pkg.sv | 19 +
 rtl/taint_sat_counter.sv | 33 +++
 rtl/taint_sink_monitor.sv | 145 ++++++++++++++
 tb/tb_taint_sink_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/taint_pkg.sv
// Shared types and helpers for the taint sink monitor.
package taint_pkg;

  localparam int unsigned TAG_W_DEF = 32;
  // Upper bound on tag width accepted by tag_violates; narrower tags are zero-extended.
  localparam int unsigned MAX_TAG_W = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ALARM = 2'd2
  } state_e;

  function automatic logic tag_violates(input logic [MAX_TAG_W-1:0] tag,
                                        input logic [MAX_TAG_W-1:0] mask);
    return |(tag & mask);
  endfunction

endpackage

// File: rtl/taint_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module taint_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/taint_sink_monitor.sv
// Checks tagged transfers at a protected sink against a policy mask and raises an alarm.
// Optional TAINT_HISTORY_EN adds seen_tag, a sticky OR of all checked tags.
module taint_sink_monitor
  import taint_pkg::*;
#(
  parameter int unsigned DATA_W         = 1,
  parameter int unsigned TAG_W          = TAG_W_DEF,
  parameter int unsigned CNT_W          = 16,
  parameter bit          STALL_ON_ALARM = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [TAG_W-1:0]  cfg_mask,
  input  logic              arm,
  input  logic              disarm,
  input  logic              ack,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic [TAG_W-1:0]  data_in_t,
  output logic              alarm,
  output logic [TAG_W-1:0]  alarm_tag,
  output logic [DATA_W-1:0] alarm_data,
  output logic [CNT_W-1:0]  viol_count,
  output logic [1:0]        state_o
`ifdef TAINT_HISTORY_EN
  ,
  output logic [TAG_W-1:0]  seen_tag
`endif
);

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    mask_q, mask_d;
  logic [TAG_W-1:0]    alarm_tag_q, alarm_tag_d;
  logic [DATA_W-1:0]   alarm_data_q, alarm_data_d;
  logic                alarm_q, alarm_d;
  logic                xfer, viol, latch, cnt_clr, cnt_inc;

  always_comb begin
    ready_out = !((state_q == ALARM) && STALL_ON_ALARM);
    xfer      = valid_in && ready_out;
    viol      = xfer && (state_q != IDLE) &&
                tag_violates(MAX_TAG_W'(data_in_t), MAX_TAG_W'(mask_q));
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    latch   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (state_q == IDLE && cfg_we) begin
      mask_d = cfg_mask;
    end
    // disarm overrides every transition and suppresses latching/counting that cycle
    if (disarm) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm) begin
            state_d = ARMED;
            cnt_clr = 1'b1;
          end
        end
        ARMED: begin
          if (viol) begin
            state_d = ALARM;
            latch   = 1'b1;
            cnt_inc = 1'b1;
          end
        end
        ALARM: begin
          if (viol) begin
            cnt_inc = 1'b1;
            latch   = ack;
          end else if (ack) begin
            state_d = ARMED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    alarm_tag_d  = latch ? (data_in_t & mask_q) : alarm_tag_q;
    alarm_data_d = latch ? data_in : alarm_data_q;
    alarm_d      = (state_d == ALARM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      alarm_tag_q  <= '0;
      alarm_data_q <= '0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      alarm_tag_q  <= alarm_tag_d;
      alarm_data_q <= alarm_data_d;
      alarm_q      <= alarm_d;
    end
  end

  taint_sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .count_o (viol_count)
  );

`ifdef TAINT_HISTORY_EN
  logic [TAG_W-1:0] seen_q, seen_d;

  always_comb begin
    seen_d = seen_q;
    if (xfer && (state_q != IDLE)) begin
      seen_d = seen_q | data_in_t;
    end
    if (state_q == IDLE && arm && !disarm) begin
      seen_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q <= '0;
    end else begin
      seen_q <= seen_d;
    end
  end

  assign seen_tag = seen_q;
`endif

  assign alarm      = alarm_q;
  assign alarm_tag  = alarm_tag_q;
  assign alarm_data = alarm_data_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_taint_sink_monitor.sv
// Three monitor configurations share one stimulus stream and are checked against a reference model.
module tb_taint_sink_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cfg_we, arm, disarm, ack, valid_in;
  logic [31:0] cfg_mask, tag_in;
  logic [3:0]  data_in;

  logic        rdy0, al0, ad0;
  logic [31:0] at0;
  logic [15:0] cnt0;
  logic [1:0]  st0;
  logic        rdy1, al1, ad1;
  logic [31:0] at1;
  logic [15:0] cnt1;
  logic [1:0]  st1;
  logic        rdy2, al2;
  logic [31:0] at2;
  logic [3:0]  ad2;
  logic [1:0]  cnt2;
  logic [1:0]  st2;
`ifdef TAINT_HISTORY_EN
  logic [31:0] seen0, seen1, seen2;
`endif

  taint_sink_monitor u0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mask(cfg_mask), .arm(arm),
    .disarm(disarm), .ack(ack), .valid_in(valid_in), .ready_out(rdy0),
    .data_in(data_in[0:0]), .data_in_t(tag_in), .alarm(al0), .alarm_tag(at0),
    .alarm_data(ad0), .viol_count(cnt0), .state_o(st0)
`ifdef TAINT_HISTORY_EN
    , .seen_tag(seen0)
`endif
  );

  taint_sink_monitor #(.STALL_ON_ALARM(1'b1)) u1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mask(cfg_mask), .arm(arm),
    .disarm(disarm), .ack(ack), .valid_in(valid_in), .ready_out(rdy1),
    .data_in(data_in[0:0]), .data_in_t(tag_in), .alarm(al1), .alarm_tag(at1),
    .alarm_data(ad1), .viol_count(cnt1), .state_o(st1)
`ifdef TAINT_HISTORY_EN
    , .seen_tag(seen1)
`endif
  );

  taint_sink_monitor #(.DATA_W(4), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mask(cfg_mask), .arm(arm),
    .disarm(disarm), .ack(ack), .valid_in(valid_in), .ready_out(rdy2),
    .data_in(data_in), .data_in_t(tag_in), .alarm(al2), .alarm_tag(at2),
    .alarm_data(ad2), .viol_count(cnt2), .state_o(st2)
`ifdef TAINT_HISTORY_EN
    , .seen_tag(seen2)
`endif
  );

  // Reference model state: 0=idle 1=armed 2=alarm
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  bit          stall[3] = '{1'b0, 1'b1, 1'b0};
  int unsigned cmax[3]  = '{65535, 65535, 3};
  logic [3:0]  dmask[3] = '{4'h1, 4'h1, 4'hF};
  logic [1:0]  m_st[3];
  logic [31:0] m_mask[3], m_tag[3], m_seen[3];
  logic [3:0]  m_data[3];
  int unsigned m_cnt[3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit rdy, xf, v;
      if (rst) begin
        m_st[k] = 2'd0; m_mask[k] = '0; m_tag[k] = '0; m_seen[k] = '0;
        m_data[k] = '0; m_cnt[k] = 0;
        continue;
      end
      rdy = !(m_st[k] == 2'd2 && stall[k]);
      xf  = valid_in && rdy;
      v   = xf && (m_st[k] != 2'd0) && ((tag_in & m_mask[k]) != 0);
      if (xf && m_st[k] != 2'd0) m_seen[k] |= tag_in;
      if (m_st[k] == 2'd0 && cfg_we) m_mask[k] = cfg_mask;
      if (disarm) begin
        m_st[k] = 2'd0;
      end else if (m_st[k] == 2'd0) begin
        if (arm) begin
          m_st[k] = 2'd1; m_cnt[k] = 0; m_seen[k] = '0;
        end
      end else begin
        if (v && m_cnt[k] < cmax[k]) m_cnt[k]++;
        if (v && (m_st[k] == 2'd1 || ack)) begin
          m_tag[k]  = tag_in & m_mask[k];
          m_data[k] = data_in & dmask[k];
        end
        if (m_st[k] == 2'd1 && v) m_st[k] = 2'd2;
        else if (m_st[k] == 2'd2 && ack && !v) m_st[k] = 2'd1;
      end
    end
  endtask

  function automatic logic exp_rdy(input int k);
    return !(m_st[k] == 2'd2 && stall[k]);
  endfunction

  task automatic check_inst(input int k, input logic al, input logic [31:0] at,
                            input logic [3:0] ad, input logic [15:0] cnt, input logic [1:0] st);
    check($sformatf("u%0d.state", k), 64'(st), 64'(m_st[k]));
    check($sformatf("u%0d.alarm", k), 64'(al), 64'(m_st[k] == 2'd2));
    check($sformatf("u%0d.alarm_tag", k), 64'(at), 64'(m_tag[k]));
    check($sformatf("u%0d.alarm_data", k), 64'(ad), 64'(m_data[k]));
    check($sformatf("u%0d.viol_count", k), 64'(cnt), 64'(m_cnt[k]));
  endtask

  task automatic cycle();
    #1;
    check("u0.ready", 64'(rdy0), 64'(exp_rdy(0)));
    check("u1.ready", 64'(rdy1), 64'(exp_rdy(1)));
    check("u2.ready", 64'(rdy2), 64'(exp_rdy(2)));
    model_step();
    @(posedge clk);
    #1;
    check_inst(0, al0, at0, {3'b0, ad0}, cnt0, st0);
    check_inst(1, al1, at1, {3'b0, ad1}, cnt1, st1);
    check_inst(2, al2, at2, ad2, {14'b0, cnt2}, st2);
`ifdef TAINT_HISTORY_EN
    check("u0.seen_tag", 64'(seen0), 64'(m_seen[0]));
    check("u1.seen_tag", 64'(seen1), 64'(m_seen[1]));
    check("u2.seen_tag", 64'(seen2), 64'(m_seen[2]));
`endif
  endtask

  task automatic idle();
    cfg_we = 1'b0; arm = 1'b0; disarm = 1'b0; ack = 1'b0; valid_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tags3[3];
    tags3 = '{32'h4, 32'hC, 32'h4};
    rst = 1'b1; cfg_mask = '0; tag_in = '0; data_in = '0; idle();
    cycle(); cycle();
    rst = 1'b0;
    check("reset.state", 64'(st0), 64'd0);
    check("reset.count", 64'(cnt0), 64'd0);
    check("reset.ready_stall", 64'(rdy1), 64'd1);

    // mask write and arm together, then a non-violating and a violating transfer
    cfg_we = 1'b1; cfg_mask = 32'h4; arm = 1'b1; cycle(); idle();
    valid_in = 1'b1; data_in = 4'h1; tag_in = 32'h3; cycle(); idle();
    check("tp.noviol.state", 64'(st0), 64'd1);
    check("tp.noviol.alarm", 64'(al0), 64'd0);
    check("tp.noviol.count", 64'(cnt0), 64'd0);
    valid_in = 1'b1; data_in = 4'h1; tag_in = 32'h4; cycle(); idle();
    check("tp.viol.alarm", 64'(al0), 64'd1);
    check("tp.viol.tag", 64'(at0), 64'h4);
    check("tp.viol.data", 64'(ad0), 64'd1);
    check("tp.viol.count", 64'(cnt0), 64'd1);
    check("tp.viol.state", 64'(st0), 64'd2);

    // further violations while in alarm
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; data_in = 4'h0; tag_in = tags3[i]; cycle();
    end
    idle();
    check("tp.multi.tag", 64'(at0), 64'h4);
    check("tp.multi.count", 64'(cnt0), 64'd4);
    check("tp.stall.ready", 64'(rdy1), 64'd0);
    check("tp.stall.count", 64'(cnt1), 64'd1);
    check("tp.sat.count", 64'(cnt2), 64'd3);
    ack = 1'b1; cycle(); idle();
    check("tp.ack.alarm", 64'(al0), 64'd0);
    check("tp.ack.state", 64'(st0), 64'd1);
    check("tp.ack.ready_stall", 64'(rdy1), 64'd1);

    // ack concurrent with a new violation
    disarm = 1'b1; cycle(); idle();
    cfg_we = 1'b1; cfg_mask = 32'hC; arm = 1'b1; cycle(); idle();
    valid_in = 1'b1; data_in = 4'h1; tag_in = 32'h4; cycle(); idle();
    ack = 1'b1; valid_in = 1'b1; data_in = 4'h0; tag_in = 32'h8; cycle(); idle();
    check("tp.ackviol.state", 64'(st0), 64'd2);
    check("tp.ackviol.tag", 64'(at0), 64'h8);
    check("tp.ackviol.count", 64'(cnt0), 64'd2);
`ifdef TAINT_HISTORY_EN
    check("tp.seen", 64'(seen0), 64'hC);
`endif

    // saturation, retention over disarm, clear on arm
    disarm = 1'b1; cycle(); idle();
    arm = 1'b1; cycle(); idle();
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1; tag_in = 32'h4; data_in = 4'(i); cycle();
    end
    idle();
    check("tp.sat5.count", 64'(cnt2), 64'd3);
    disarm = 1'b1; cycle(); idle();
    check("tp.disarm.state", 64'(st2), 64'd0);
    check("tp.disarm.count", 64'(cnt2), 64'd3);
    arm = 1'b1; cycle(); idle();
    check("tp.rearm.count", 64'(cnt2), 64'd0);

    // zero mask never violates
    disarm = 1'b1; cycle(); idle();
    cfg_we = 1'b1; cfg_mask = 32'h0; arm = 1'b1; cycle(); idle();
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; tag_in = 32'hFFFF_FFFF; cycle();
    end
    idle();
    check("tp.zeromask.state", 64'(st0), 64'd1);
    check("tp.zeromask.count", 64'(cnt0), 64'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 499) == 0);
      cfg_we   = ($urandom_range(0, 9) == 0);
      cfg_mask = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & 32'h1F);
      arm      = ($urandom_range(0, 14) == 0);
      disarm   = ($urandom_range(0, 39) == 0);
      ack      = ($urandom_range(0, 5) == 0);
      valid_in = ($urandom_range(0, 2) != 0);
      tag_in   = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'h1F);
      data_in  = 4'($urandom);
      cycle();
    end
    rst = 1'b0; idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
